// File: rtl/sf.sv
// sf: LFSR sequence feeder over a req/rdy handshake; define SF_CHECKSUM_EN to append an XOR checksum word
module sf #(
  parameter int unsigned COUNT = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rdy,
  output logic        req,
  output logic [15:0] dat,
  output logic        busy,
  output logic        done,
  output logic [15:0] count
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;
`ifdef SF_CHECKSUM_EN
  localparam logic [15:0] LAST = 16'(COUNT);
`else
  localparam logic [15:0] LAST = 16'(COUNT - 1);
`endif
  state_t      state_q, state_d;
  logic        start_q, req_q, req_d, busy_q, busy_d;
  logic [15:0] lfsr_q, lfsr_d, dat_q, dat_d, count_q, count_d, lfsr_nx;
  logic        start_edge, xfer, last;
`ifdef SF_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
`endif
  assign start_edge = start & ~start_q;
  assign xfer       = req_q & rdy;
  assign last       = count_q == LAST;
  assign lfsr_nx    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign req        = req_q;
  assign dat        = dat_q;
  assign busy       = busy_q;
  assign count      = count_q;
  // state and datapath registers; reset aborts any burst without a done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      lfsr_q  <= SEED;
      dat_q   <= '0;
      count_q <= '0;
`ifdef SF_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start;
      req_q   <= req_d;
      busy_q  <= busy_d;
      lfsr_q  <= lfsr_d;
      dat_q   <= dat_d;
      count_q <= count_d;
`ifdef SF_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
  // next state: start edges only matter in IDLE, so they are never queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start_edge ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = S_SEND;
      S_SEND:  state_d = (xfer && last) ? S_DONE : S_SEND;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs and datapath: first SEND cycle presents the seed, each transfer advances the word
  always_comb begin
    lfsr_d  = lfsr_q;
    dat_d   = dat_q;
    req_d   = req_q;
    busy_d  = busy_q;
    count_d = count_q;
`ifdef SF_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    done    = state_q == S_DONE;
    case (state_q)
      S_LOAD: begin
        lfsr_d  = SEED;
        count_d = '0;
        busy_d  = 1'b1;
`ifdef SF_CHECKSUM_EN
        csum_d  = '0;
`endif
      end
      S_SEND: begin
        if (!req_q) begin
          req_d = 1'b1;
          dat_d = lfsr_q;
        end else if (xfer) begin
          count_d = count_q + 16'd1;
          lfsr_d  = lfsr_nx;
          req_d   = !last;
`ifdef SF_CHECKSUM_EN
          csum_d  = csum_q ^ dat_q;
          dat_d   = (count_q == 16'(COUNT - 1)) ? csum_q ^ dat_q : lfsr_nx;
`else
          dat_d   = lfsr_nx;
`endif
        end
      end
      S_DONE:  busy_d = 1'b0;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sf.sv
// tb_sf: randomized self-checking bench for sf against a word-sequence reference model
module tb_sf;
  localparam int ND = 16;
`ifdef SF_CHECKSUM_EN
  localparam int N = ND + 1;
`else
  localparam int N = ND;
`endif
  logic clk = 0, rst = 1, start = 0, rdy = 0;
  logic req, busy, done;
  logic [15:0] dat, count;
  int tests = 0, fails = 0;
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  int done_cnt = 0, req_cyc = 0, stall_err = 0;
  logic [15:0] done_val = 0;
  logic stall_p = 0;
  logic [15:0] stall_d = 0;

  sf #(.COUNT(ND), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .rdy(rdy),
    .req(req), .dat(dat), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // monitor at negedge: inputs change at posedge+1, so req&&rdy here means a transfer at the next posedge
  always @(negedge clk) begin
    if (rst) begin
      if (stall_p && !(req && dat == stall_d)) stall_err++;
      stall_p = req && !rdy;
      stall_d = dat;
      if (req) req_cyc++;
      if (req && rdy) got.push_back(dat);
      if (done) begin
        done_cnt++;
        done_val = count;
      end
    end else stall_p = 0;
  end

  function automatic void build_exp();
    int l, x, fb;
    l = 'hACE1;
    x = 0;
    for (int i = 0; i < ND; i++) begin
      exp_q.push_back(16'(l));
      x = x ^ l;
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      l = ((l << 1) | fb) & 'hFFFF;
    end
`ifdef SF_CHECKSUM_EN
    exp_q.push_back(16'(x));
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    for (int i = 0; i < budget && done_cnt == base; i++) tick(1);
    ok = done_cnt != base;
  endtask

  task automatic test_reset();
    #2 rst = 0;
    #1;
    tests++; if ({req, busy, done} !== 3'b000) begin fails++; $display("FAIL reset_ctl got %b want 000", {req, busy, done}); end
    tests++; if (dat !== 16'h0) begin fails++; $display("FAIL reset_dat got %h want 0000", dat); end
    tests++; if (count !== 16'h0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tick(2);
    rst = 1;
    tick(3);
    tests++; if ({req, busy, done} !== 3'b000) begin fails++; $display("FAIL idle_ctl got %b want 000", {req, busy, done}); end
  endtask

  task automatic test_basic();
    int bg, bd, br;
    bit ok;
    bg = got.size(); bd = done_cnt; br = req_cyc;
    start = 1; rdy = 1;
    tick(1);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL lat_busy_early got %b want 0", busy); end
    tick(1);
    tests++; if ({busy, req} !== 2'b10) begin fails++; $display("FAIL lat_busy got %b want 10", {busy, req}); end
    tick(1);
    tests++; if (req !== 1'b1 || dat !== 16'hACE1) begin fails++; $display("FAIL lat_req got req=%b dat=%h want 1 ace1", req, dat); end
    wait_done(bd, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_timeout got no done want done"); end
    tick(80);
    tests++; if (done_cnt - bd !== 1) begin fails++; $display("FAIL basic_done got %0d want 1", done_cnt - bd); end
    tests++; if (done_val !== 16'(N)) begin fails++; $display("FAIL basic_done_count got %0d want %0d", done_val, N); end
    tests++; if (req_cyc - br !== N) begin fails++; $display("FAIL basic_req_cycles got %0d want %0d", req_cyc - br, N); end
    tests++; if (got.size() - bg !== N) begin fails++; $display("FAIL basic_xfers got %0d want %0d", got.size() - bg, N); end
    tests++; if (got[bg+1] !== 16'h59C3 || got[bg+2] !== 16'hB387) begin fails++; $display("FAIL basic_words12 got %h %h want 59c3 b387", got[bg+1], got[bg+2]); end
    for (int i = 0; i < N && bg + i < got.size(); i++) begin
      tests++; if (got[bg+i] !== exp_q[i]) begin fails++; $display("FAIL basic_word%0d got %h want %h", i, got[bg+i], exp_q[i]); end
    end
    tests++; if (busy !== 1'b0 || count !== 16'(N)) begin fails++; $display("FAIL basic_end got busy=%b count=%0d want 0 %0d", busy, count, N); end
    start = 0;
    tick(2);
  endtask

  task automatic test_backpressure();
    int bg, bd, se;
    bit ok;
    bg = got.size(); bd = done_cnt; se = stall_err;
    start = 1;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      rdy = 1'($urandom_range(0, 1));
      tick(1);
      ok = done_cnt != bd;
    end
    rdy = 1;
    tests++; if (!ok) begin fails++; $display("FAIL bp_timeout got no done want done"); end
    tick(3);
    tests++; if (stall_err - se !== 0) begin fails++; $display("FAIL bp_stable got %0d violations want 0", stall_err - se); end
    tests++; if (got.size() - bg !== N) begin fails++; $display("FAIL bp_xfers got %0d want %0d", got.size() - bg, N); end
    for (int i = 0; i < N && bg + i < got.size(); i++) begin
      tests++; if (got[bg+i] !== exp_q[i]) begin fails++; $display("FAIL bp_word%0d got %h want %h", i, got[bg+i], exp_q[i]); end
    end
    tests++; if (count !== 16'(N) || done_cnt - bd !== 1) begin fails++; $display("FAIL bp_end got count=%0d dones=%0d want %0d 1", count, done_cnt - bd, N); end
    start = 0;
    tick(2);
  endtask

  task automatic test_retrigger();
    int bg, bd;
    bit ok;
    bg = got.size(); bd = done_cnt;
    start = 1; rdy = 1;
    for (int i = 0; i < 50 && got.size() - bg < 3; i++) tick(1);
    start = 0; tick(2);
    start = 1; tick(2);
    start = 0;
    wait_done(bd, 200, ok);
    tick(30);
    tests++; if (!ok || done_cnt - bd !== 1) begin fails++; $display("FAIL retrig_done got %0d want 1", done_cnt - bd); end
    tests++; if (got.size() - bg !== N) begin fails++; $display("FAIL retrig_xfers got %0d want %0d", got.size() - bg, N); end
    bg = got.size(); bd = done_cnt;
    start = 1;
    wait_done(bd, 200, ok);
    tick(2);
    tests++; if (!ok) begin fails++; $display("FAIL retrig_timeout got no done want done"); end
    tests++; if (got.size() - bg !== N || got[bg] !== 16'hACE1) begin fails++; $display("FAIL retrig_restart got n=%0d first=%h want %0d ace1", got.size() - bg, got[bg], N); end
    start = 0;
    tick(2);
  endtask

  task automatic test_abort();
    int bg, bd;
    bit ok;
    bd = done_cnt;
    start = 1; rdy = 1;
    for (int i = 0; i < 60 && count !== 16'd5; i++) tick(1);
    tests++; if (count !== 16'd5) begin fails++; $display("FAIL abort_setup got count=%0d want 5", count); end
    rst = 0;
    #1;
    tests++; if ({req, busy, done} !== 3'b000 || count !== 16'h0 || dat !== 16'h0) begin fails++; $display("FAIL abort_clear got req=%b busy=%b done=%b count=%0d dat=%h want all 0", req, busy, done, count, dat); end
    tick(5);
    tests++; if (done_cnt !== bd) begin fails++; $display("FAIL abort_no_done got %0d want %0d", done_cnt, bd); end
    bg = got.size();
    rst = 1;
    wait_done(bd, 200, ok);
    tick(2);
    tests++; if (!ok) begin fails++; $display("FAIL abort_restart_timeout got no done want done"); end
    tests++; if (got.size() - bg !== N) begin fails++; $display("FAIL abort_xfers got %0d want %0d", got.size() - bg, N); end
    for (int i = 0; i < N && bg + i < got.size(); i++) begin
      tests++; if (got[bg+i] !== exp_q[i]) begin fails++; $display("FAIL abort_word%0d got %h want %h", i, got[bg+i], exp_q[i]); end
    end
    tests++; if (count !== 16'(N)) begin fails++; $display("FAIL abort_count got %0d want %0d", count, N); end
    start = 0;
    tick(2);
  endtask

  initial begin
    build_exp();
    test_reset();
    test_basic();
    test_backpressure();
    test_retrigger();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sf.md
# sf

Sequence feeder: on a start request, streams a fixed-length burst of pseudo-random 16-bit words out over a req/rdy valid-ready handshake, then signals completion. It sits at the head of the datapath as a self-contained stimulus/data source, replayable from a known seed on every start.

## Interface
- `COUNT`, 16: words per burst; legal range 1..65535.
- `SEED`, 16'hACE1: LFSR load value at burst start; must be non-zero.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `start` input 1: burst request, level input; only a 0->1 transition as sampled on `clk` triggers.
- `rdy` input 1: consumer ready.
- `req` output 1: `dat` valid.
- `dat` output 16: data word.
- `busy` output 1: high from LOAD until the burst ends, inclusive of DONE.
- `done` output 1: one-cycle pulse at burst end.
- `count` output 16: words transferred in current/last burst.

## Operation
- Start edge detect: `start_q` registers `start`. The edge is `start & ~start_q`.
- States: IDLE, LOAD, SEND, DONE.
- IDLE -> LOAD on an edge.
- LOAD: `lfsr <= SEED`, `count <= 0`, `busy <= 1`. Then go to SEND with `req <= 1` and `dat <= SEED`.
- SEND: a transfer occurs on a posedge with `req && rdy`.
  - On a transfer: `count++` and `lfsr` advances.
  - If more words remain, `dat <= next lfsr` and `req` stays high (back-to-back transfers allowed).
  - If that was the last word: `req <= 0` and go to DONE.
- DONE: `done = 1` for exactly one cycle and `busy = 1`. Then IDLE with `busy <= 0`. `count` holds its final value until the next LOAD.
- LFSR step: `next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}` (x^16+x^14+x^13+x^11+1).
- While `req && !rdy`, `dat` and `req` hold stable. `req` never drops before the transfer.
- Start edges in any state other than IDLE are ignored. They are not queued.
- `count` is 16-bit; `COUNT` ≤ 65535, so it never wraps.

## Timing
- Reset values: `req=0`, `dat=0`, `busy=0`, `done=0`, `count=0`, state IDLE, `start_q=0`, `lfsr=SEED`.
- Latency: edge sampled at posedge t -> `busy` high after t+1 -> `req` high with `dat=SEED` after t+2.
- With `rdy` held high, a burst takes COUNT cycles of `req`. `done` follows 1 cycle after the last transfer. IDLE is reached 1 cycle later.
- Reset during a burst: immediate abort to reset values. No `done` pulse.
- After reset release with `start` already high: `start_q=0`, so this counts as an edge and a burst begins.
- `start` held high across the whole burst does not retrigger. A new burst requires `start` to go low, then high, while in IDLE.

## Configuration
- `SF_CHECKSUM_EN` defined: after the COUNT data words, one extra word is sent through the same handshake (COUNT+1 transfers). That word is the XOR of all COUNT data words.
  - `count` ends at COUNT+1.
  - `done` follows the checksum transfer.
- `SF_CHECKSUM_EN` undefined: exactly COUNT transfers. No checksum logic.

## Test plan
- Reset: drive `rst=0` mid-simulation -> all outputs 0 immediately (asynchronous). Release -> IDLE.
- Basic burst, COUNT=16, `rdy=1`, `start` 0->1 held 100 cycles:
  - `req` rises 2 cycles after `start` is sampled high.
  - `dat` sequence begins 0xACE1, 0x59C3, 0xB387.
  - 16 transfers, then a single-cycle `done` with `count=16`, exactly one burst.
- Backpressure: toggle `rdy` pseudo-randomly -> `dat` stable while `req && !rdy`. Same word sequence as the basic burst. `count=16`.
- Retrigger: pulse `start` again during SEND -> ignored. A fresh 0->1 in IDLE -> new burst restarts at 0xACE1.
- Abort: `rst` low after 5 transfers -> `req=0`, `count=0`, no `done`. The next start runs a full burst from SEED.
- With `SF_CHECKSUM_EN`, COUNT=2 -> words 0xACE1, 0x59C3, then checksum 0xF522. `count=3`.
